button_pulse_conditioner: RTL and testbench

Front-end conditioner for one raw pushbutton and a 4-bit switch bank. It synchronizes both inputs, debounces the button, and emits a single-cycle press pulse together with a switch nibble captured coherently with that pulse. Its outputs drive the access controller's `b_ac` and `swt_ac` inputs directly. That controller treats `b_ac` as a one-cycle strobe, so exactly one pulse per physical press is mandatory.

---
 rtl/button_pulse_conditioner.sv | 190 +++++++++++++++++++
 tb/tb_button_pulse_conditioner.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_pulse_conditioner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// button_pulse_conditioner
//
// Front end for one raw pushbutton and a 4-bit switch bank feeding the access
// controller. Both inputs are brought into the clk domain through two-flop
// synchronizers. The button is debounced by a small FSM, and each accepted
// press produces exactly one single-cycle strobe on b_ac. The synchronized
// switch nibble is captured on the same edge that raises b_ac, so swt_ac is
// already valid while the strobe is high.
//
// Build option (macro BUTTON_DEBOUNCE_EN):
//   defined   - full debounce: a press or release must be stable for
//               DB_CYCLES+1 consecutive synchronized samples to be accepted.
//   undefined - fast-simulation build: the debounce states and the counter are
//               not built, so a press is accepted on the first synchronized
//               sample and a release on the first released sample.
//
// Parameters:
//   DB_CYCLES  stable-input cycles required to accept a press/release (>= 2)
//   CNT_W      debounce counter width, 2**CNT_W must exceed DB_CYCLES
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-low
//   btn_n      raw pushbutton, active-low, asynchronous to clk
//   swt_raw    raw switches, asynchronous to clk
//   b_ac       press strobe, one cycle per accepted press
//   swt_ac     switch value captured with the strobe, held until next press
//   btn_level  debounced button level (1 = pressed)
//   press_cnt  accepted-press count, modulo 256
// -----------------------------------------------------------------------------
module button_pulse_conditioner #(
   parameter int DB_CYCLES = 500000,
   parameter int CNT_W     = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_n,
   input  logic [3:0] swt_raw,
   output logic       b_ac,
   output logic [3:0] swt_ac,
   output logic       btn_level,
   output logic [7:0] press_cnt
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PRESS_DB = 3'd1,
      S_PULSE    = 3'd2,
      S_HELD     = 3'd3,
      S_REL_DB   = 3'd4
   } state_t;

   logic       r_btn_sync1;
   logic       r_btn_sync2;
   logic [3:0] r_swt_sync1;
   logic [3:0] r_swt_sync2;
   logic       w_btn_s;

   state_t     r_state;
   logic       r_b_ac;
   logic       r_btn_level;
   logic [3:0] r_swt_ac;
   logic [7:0] r_press_cnt;

`ifdef BUTTON_DEBOUNCE_EN
   // Terminal count: reaching it with the input still stable accepts the edge.
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_cnt;
`endif

   // An out-of-range configuration elaborates this named marker block, which
   // makes a bad DB_CYCLES/CNT_W pairing visible in the elaborated hierarchy.
   if ((DB_CYCLES < 2) || (CNT_W < 2) || (CNT_W > 62) ||
       ((64'd1 << CNT_W) <= 64'(DB_CYCLES))) begin : g_bad_debounce_config
   end

   // Two-flop synchronizers; the button resets to "released" (btn_n high).
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_btn_sync1 <= 1'b1;
         r_btn_sync2 <= 1'b1;
         r_swt_sync1 <= 4'h0;
         r_swt_sync2 <= 4'h0;
      end else begin
         r_btn_sync1 <= btn_n;
         r_btn_sync2 <= r_btn_sync1;
         r_swt_sync1 <= swt_raw;
         r_swt_sync2 <= r_swt_sync1;
      end
   end

   // Synchronized button, active-high (1 = pressed).
   assign w_btn_s = ~r_btn_sync2;

   // Debounce FSM with registered strobe, level and switch capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_b_ac      <= 1'b0;
         r_btn_level <= 1'b0;
         r_swt_ac    <= 4'h0;
         r_press_cnt <= 8'd0;
`ifdef BUTTON_DEBOUNCE_EN
         r_cnt       <= C_CNT_ZERO;
`endif
      end else begin
         // The strobe is only ever raised on the edge that enters PULSE.
         r_b_ac <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_btn_s) begin
`ifdef BUTTON_DEBOUNCE_EN
                  r_state <= S_PRESS_DB;
                  r_cnt   <= C_CNT_ZERO;
`else
                  r_state     <= S_PULSE;
                  r_b_ac      <= 1'b1;
                  r_btn_level <= 1'b1;
                  r_swt_ac    <= r_swt_sync2;
`endif
               end else begin
                  r_state <= S_IDLE;
               end
            end
`ifdef BUTTON_DEBOUNCE_EN
            S_PRESS_DB: begin
               if (!w_btn_s) begin
                  // Glitch shorter than the debounce window: drop it.
                  r_state <= S_IDLE;
               end else if (r_cnt == C_CNT_LAST) begin
                  r_state     <= S_PULSE;
                  r_b_ac      <= 1'b1;
                  r_btn_level <= 1'b1;
                  r_swt_ac    <= r_swt_sync2;
               end else begin
                  r_cnt <= r_cnt + C_CNT_ONE;
               end
            end
`endif
            S_PULSE: begin
               // Counted on the way out so the count and strobe never overlap.
               r_state     <= S_HELD;
               r_press_cnt <= r_press_cnt + 8'd1;
            end
            S_HELD: begin
               if (!w_btn_s) begin
`ifdef BUTTON_DEBOUNCE_EN
                  r_state <= S_REL_DB;
                  r_cnt   <= C_CNT_ZERO;
`else
                  r_state     <= S_IDLE;
                  r_btn_level <= 1'b0;
`endif
               end else begin
                  r_state <= S_HELD;
               end
            end
`ifdef BUTTON_DEBOUNCE_EN
            S_REL_DB: begin
               if (w_btn_s) begin
                  // Release bounce: still pressed, and no new strobe.
                  r_state <= S_HELD;
               end else if (r_cnt == C_CNT_LAST) begin
                  r_state     <= S_IDLE;
                  r_btn_level <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + C_CNT_ONE;
               end
            end
`endif
            default: begin
               // Unreachable encodings recover to a released, idle button.
               r_state     <= S_IDLE;
               r_btn_level <= 1'b0;
            end
         endcase
      end
   end

   assign b_ac      = r_b_ac;
   assign btn_level = r_btn_level;
   assign swt_ac    = r_swt_ac;
   assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
`timescale 1ns/1ps
// Self-checking bench for button_pulse_conditioner. The reference model works
// on edge-indexed histories of the raw inputs: a synchronized sample is the raw
// value two edges earlier (released/zero if a reset hit either edge), a press
// is accepted once N+1 consecutive pressed samples have been seen since the
// button was last listened to, and a release likewise. N is DB_CYCLES in the
// debounced build and 0 in the fast build.
module tb_button_pulse_conditioner;

   localparam int DB = 8;
`ifdef BUTTON_DEBOUNCE_EN
   localparam int N = DB;
`else
   localparam int N = 0;
`endif
   localparam int LAT  = N + 3;   // strobe seen after edge LAT when first low sample is edge 1
   localparam int MAXE = 16384;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_n = 1'b1;
   logic [3:0] swt_raw = 4'h0;
   logic       b_ac;
   logic [3:0] swt_ac;
   logic       btn_level;
   logic [7:0] press_cnt;

   button_pulse_conditioner #(.DB_CYCLES(DB), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .btn_n(btn_n), .swt_raw(swt_raw),
      .b_ac(b_ac), .swt_ac(swt_ac), .btn_level(btn_level), .press_cnt(press_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // model histories and state
   int         edge_no = 0;
   bit         raw_b [MAXE];
   logic [3:0] raw_s [MAXE];
   bit         rstv  [MAXE];
   bit         bs_h  [MAXE];
   bit         m_level = 1'b0;
   bit         m_pulse = 1'b0;
   logic [3:0] m_swt = 4'h0;
   logic [7:0] m_cnt = 8'd0;
   int         listen_from = 0;
   int         m_pulses = 0;

   // observations of the DUT (not checks)
   int         dut_pulses = 0;
   int         last_pulse_edge = -1;
   int         last_fall_edge = -1;
   logic [3:0] last_pulse_swt = 4'h0;
   logic       prev_level = 1'b0;

   task automatic model_edge(input bit b, input logic [3:0] s, input bit r);
      int t;
      bit ok;
      bit valid;
      logic [3:0] sw;
      t = edge_no;
      raw_b[t] = b;
      raw_s[t] = s;
      rstv[t]  = r;
      if (!r) begin
         m_level = 1'b0; m_pulse = 1'b0; m_swt = 4'h0; m_cnt = 8'd0;
         listen_from = t + 1;
         bs_h[t] = 1'b0;
      end else begin
         if (m_pulse) m_cnt = m_cnt + 8'd1;
         m_pulse = 1'b0;
         valid   = (t >= 2) && rstv[t-1] && rstv[t-2];
         bs_h[t] = valid ? !raw_b[t-2] : 1'b0;
         sw      = valid ? raw_s[t-2] : 4'h0;
         if (t - N >= listen_from) begin
            ok = 1'b1;
            for (int k = t - N; k <= t; k++) if (bs_h[k] == m_level) ok = 1'b0;
            if (ok) begin
               if (!m_level) begin
                  m_pulse = 1'b1; m_swt = sw; m_pulses++;
                  listen_from = t + 2;
               end else begin
                  listen_from = t + 1;
               end
               m_level = !m_level;
            end
         end
      end
      edge_no++;
   endtask

   // Drive one edge worth of inputs, advance the model, sample on the falling edge.
   task automatic step(input bit b, input logic [3:0] s, input bit r);
      if (edge_no >= MAXE - 1) begin
         $display("FAIL edge_budget edges=%0d limit=%0d", edge_no, MAXE);
         $fatal(1, "edge budget exhausted");
      end
      btn_n = b; swt_raw = s; rst = r;
      model_edge(b, s, r);
      @(posedge clk);
      @(negedge clk);
      if (b_ac === 1'b1) begin
         dut_pulses++; last_pulse_edge = edge_no - 1; last_pulse_swt = swt_ac;
      end
      if (prev_level === 1'b1 && btn_level === 1'b0) last_fall_edge = edge_no - 1;
      prev_level = btn_level;
   endtask

   task automatic clear_obs();
      dut_pulses = 0; m_pulses = 0; last_pulse_edge = -1; last_fall_edge = -1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'hF, 1'b0);
         checks++;
         if ({b_ac, btn_level, swt_ac, press_cnt} !== 14'd0)
            $display("FAIL reset_outputs got=%h want=%h", {b_ac, btn_level, swt_ac, press_cnt}, 14'd0);
         else passed++;
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'hF, 1'b1);
         checks++;
         if ({b_ac, btn_level, swt_ac, press_cnt} !== {m_pulse, m_level, m_swt, m_cnt})
            $display("FAIL reset_idle edge=%0d got=%h want=%h", edge_no - 1,
                     {b_ac, btn_level, swt_ac, press_cnt}, {m_pulse, m_level, m_swt, m_cnt});
         else passed++;
      end
   endtask

   task automatic test_clean_press();
      int k;
      int r0;
      clear_obs();
      k = edge_no;
      for (int i = 0; i < 60; i++) begin
         if (i == 30) r0 = edge_no;
         step((i < 30) ? 1'b0 : 1'b1, 4'hA, 1'b1);
         checks++;
         if ({b_ac, btn_level, swt_ac, press_cnt} !== {m_pulse, m_level, m_swt, m_cnt})
            $display("FAIL clean_cycle edge=%0d got=%h want=%h", edge_no - 1,
                     {b_ac, btn_level, swt_ac, press_cnt}, {m_pulse, m_level, m_swt, m_cnt});
         else passed++;
      end
      checks++;
      if (dut_pulses !== 1) $display("FAIL clean_pulse_count got=%0d want=%0d", dut_pulses, 1);
      else passed++;
      checks++;
      if (last_pulse_edge !== k + LAT - 1)
         $display("FAIL clean_press_latency got_edge=%0d want_edge=%0d", last_pulse_edge, k + LAT - 1);
      else passed++;
      checks++;
      if (last_pulse_swt !== 4'hA) $display("FAIL clean_swt_capture got=%h want=%h", last_pulse_swt, 4'hA);
      else passed++;
      checks++;
      if (press_cnt !== 8'd1) $display("FAIL clean_press_cnt got=%0d want=%0d", press_cnt, 1);
      else passed++;
      checks++;
      if (last_fall_edge !== r0 + LAT - 1)
         $display("FAIL clean_release_latency got_edge=%0d want_edge=%0d", last_fall_edge, r0 + LAT - 1);
      else passed++;
   endtask

   task automatic test_press_bounce();
      int seq [4];
      int lvl [4];
      int final_fall;
      seq = '{4, 1, 30, 30};
      lvl = '{0, 1, 0, 1};
      clear_obs();
      final_fall = -1;
      for (int s = 0; s < 4; s++) begin
         if (s == 2) final_fall = edge_no;
         for (int i = 0; i < seq[s]; i++) begin
            step(lvl[s][0], 4'h5, 1'b1);
            checks++;
            if ({b_ac, btn_level, swt_ac, press_cnt} !== {m_pulse, m_level, m_swt, m_cnt})
               $display("FAIL press_bounce_cycle edge=%0d got=%h want=%h", edge_no - 1,
                        {b_ac, btn_level, swt_ac, press_cnt}, {m_pulse, m_level, m_swt, m_cnt});
            else passed++;
         end
      end
      checks++;
      if (dut_pulses !== m_pulses) $display("FAIL press_bounce_count got=%0d want=%0d", dut_pulses, m_pulses);
      else passed++;
      checks++;
      if (last_pulse_edge !== final_fall + LAT - 1)
         $display("FAIL press_bounce_latency got_edge=%0d want_edge=%0d", last_pulse_edge, final_fall + LAT - 1);
      else passed++;
   endtask

   task automatic test_release_bounce();
      int seq [4];
      int lvl [4];
      int final_rise;
      seq = '{30, 3, 5, 30};
      lvl = '{0, 1, 0, 1};
      clear_obs();
      final_rise = -1;
      for (int s = 0; s < 4; s++) begin
         if (s == 3) final_rise = edge_no;
         for (int i = 0; i < seq[s]; i++) begin
            step(lvl[s][0], 4'h6, 1'b1);
            checks++;
            if ({b_ac, btn_level, swt_ac, press_cnt} !== {m_pulse, m_level, m_swt, m_cnt})
               $display("FAIL release_bounce_cycle edge=%0d got=%h want=%h", edge_no - 1,
                        {b_ac, btn_level, swt_ac, press_cnt}, {m_pulse, m_level, m_swt, m_cnt});
            else passed++;
         end
      end
      checks++;
      if (dut_pulses !== m_pulses) $display("FAIL release_bounce_count got=%0d want=%0d", dut_pulses, m_pulses);
      else passed++;
      checks++;
      if (last_fall_edge !== final_rise + LAT - 1)
         $display("FAIL release_bounce_latency got_edge=%0d want_edge=%0d", last_fall_edge, final_rise + LAT - 1);
      else passed++;
   endtask

   task automatic test_random();
      bit b;
      logic [3:0] s;
      int len;
      clear_obs();
      b = 1'b1;
      for (int seg = 0; seg < 60; seg++) begin
         b   = $urandom_range(0, 1);
         len = $urandom_range(1, N + 6);
         s   = 4'($urandom_range(0, 15));
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) s = 4'($urandom_range(0, 15));
            step(b, s, 1'b1);
            checks++;
            if ({b_ac, btn_level, swt_ac, press_cnt} !== {m_pulse, m_level, m_swt, m_cnt})
               $display("FAIL random_cycle edge=%0d got=%h want=%h", edge_no - 1,
                        {b_ac, btn_level, swt_ac, press_cnt}, {m_pulse, m_level, m_swt, m_cnt});
            else passed++;
         end
      end
      checks++;
      if (dut_pulses !== m_pulses) $display("FAIL random_pulse_count got=%0d want=%0d", dut_pulses, m_pulses);
      else passed++;
   endtask

   task automatic test_wrap();
      logic [3:0] s;
      step(1'b1, 4'h0, 1'b0);
      step(1'b1, 4'h0, 1'b0);
      clear_obs();
      for (int p = 0; p < 256; p++) begin
         s = 4'($urandom_range(0, 15));
         for (int i = 0; i < 2 * (LAT + 4); i++) begin
            step((i < LAT + 4) ? 1'b0 : 1'b1, s, 1'b1);
            checks++;
            if ({b_ac, btn_level, swt_ac, press_cnt} !== {m_pulse, m_level, m_swt, m_cnt})
               $display("FAIL wrap_cycle edge=%0d got=%h want=%h", edge_no - 1,
                        {b_ac, btn_level, swt_ac, press_cnt}, {m_pulse, m_level, m_swt, m_cnt});
            else passed++;
         end
      end
      checks++;
      if (dut_pulses !== 256) $display("FAIL wrap_pulse_count got=%0d want=%0d", dut_pulses, 256);
      else passed++;
      checks++;
      if (press_cnt !== 8'd0) $display("FAIL wrap_press_cnt got=%0d want=%0d", press_cnt, 0);
      else passed++;
   endtask

   task automatic test_reset_mid_debounce();
      int k;
      clear_obs();
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'h9, 1'b1);
         checks++;
         if ({b_ac, btn_level, swt_ac, press_cnt} !== {m_pulse, m_level, m_swt, m_cnt})
            $display("FAIL middb_cycle edge=%0d got=%h want=%h", edge_no - 1,
                     {b_ac, btn_level, swt_ac, press_cnt}, {m_pulse, m_level, m_swt, m_cnt});
         else passed++;
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 4'h9, 1'b0);
         checks++;
         if ({b_ac, btn_level, swt_ac, press_cnt} !== 14'd0)
            $display("FAIL middb_reset_outputs got=%h want=%h", {b_ac, btn_level, swt_ac, press_cnt}, 14'd0);
         else passed++;
      end
      clear_obs();
      k = edge_no;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 4'h9, 1'b1);
         checks++;
         if ({b_ac, btn_level, swt_ac, press_cnt} !== {m_pulse, m_level, m_swt, m_cnt})
            $display("FAIL middb_held_cycle edge=%0d got=%h want=%h", edge_no - 1,
                     {b_ac, btn_level, swt_ac, press_cnt}, {m_pulse, m_level, m_swt, m_cnt});
         else passed++;
      end
      checks++;
      if (dut_pulses !== 1) $display("FAIL middb_repress_count got=%0d want=%0d", dut_pulses, 1);
      else passed++;
      checks++;
      if (last_pulse_edge !== k + LAT - 1)
         $display("FAIL middb_repress_latency got_edge=%0d want_edge=%0d", last_pulse_edge, k + LAT - 1);
      else passed++;
      checks++;
      if (last_pulse_swt !== 4'h9) $display("FAIL middb_swt_capture got=%h want=%h", last_pulse_swt, 4'h9);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_press_bounce();
      test_release_bounce();
      test_random();
      test_wrap();
      test_reset_mid_debounce();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
